// File: rtl/virtio_csr_pkg.sv
// Shared constants for the legacy virtio-PCI common configuration block:
// register byte offsets, status/ISR bit positions and the address decoder.
package virtio_csr_pkg;

    localparam logic [31:0] OFF_DEV_FEAT          = 32'h00;
    localparam logic [31:0] OFF_GUEST_FEAT        = 32'h04;
    localparam logic [31:0] OFF_QUEUE_ADDR        = 32'h08;
    localparam logic [31:0] OFF_QUEUE_SIZE_SEL    = 32'h0C;
    localparam logic [31:0] OFF_NOTIFY_STATUS_ISR = 32'h10;
    localparam logic [31:0] OFF_MSIX              = 32'h14;
    localparam logic [31:0] OFF_CFG               = 32'h18;

    localparam logic [15:0] NO_VECTOR = 16'hFFFF;

    localparam int unsigned STATUS_ACK       = 0;
    localparam int unsigned STATUS_DRIVER    = 1;
    localparam int unsigned STATUS_DRIVER_OK = 2;
    localparam int unsigned STATUS_FAILED    = 7;

    localparam int unsigned ISR_QUEUE  = 0;
    localparam int unsigned ISR_CONFIG = 1;

    typedef enum logic [2:0] {
        REG_DEV_FEAT,
        REG_GUEST_FEAT,
        REG_QUEUE_ADDR,
        REG_QUEUE_SIZE_SEL,
        REG_NOTIFY_STATUS_ISR,
        REG_MSIX,
        REG_CFG,
        REG_NONE
    } reg_e;

    // waddr is the word-aligned byte address; cfg_end is one past the config RAM.
    function automatic reg_e decode_reg(input logic [31:0] waddr, input logic [31:0] cfg_end);
        reg_e r;
        r = REG_NONE;
        if (waddr >= OFF_CFG && waddr < cfg_end) begin
            r = REG_CFG;
        end else begin
            case (waddr)
                OFF_DEV_FEAT:          r = REG_DEV_FEAT;
                OFF_GUEST_FEAT:        r = REG_GUEST_FEAT;
                OFF_QUEUE_ADDR:        r = REG_QUEUE_ADDR;
                OFF_QUEUE_SIZE_SEL:    r = REG_QUEUE_SIZE_SEL;
                OFF_NOTIFY_STATUS_ISR: r = REG_NOTIFY_STATUS_ISR;
                OFF_MSIX:              r = REG_MSIX;
                default:               r = REG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/virtio_csr_mq_cfg_ram.sv
// Device-specific config space: single-port, byte-write, read-first RAM with
// one cycle of read latency. Output holds while the port is idle.
module virtio_cfg_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   din_i,
    output logic [31:0]   dout_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int unsigned b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= din_i[8*b +: 8];
                end
            end
        end
    end

    assign dout_o = rdata_q;

endmodule

// File: rtl/virtio_csr_mq.sv
// Legacy virtio-PCI common config registers for NUM_QUEUES virtqueues, with
// notify/MSI-X request outputs and a byte-write device config RAM.
module virtio_csr_mq
    import virtio_csr_pkg::*;
#(
    parameter int unsigned NUM_QUEUES      = 3,
    parameter int unsigned QUEUE_SIZE      = 256,
    parameter logic [31:0] DEVICE_FEATURES = 32'h0000_0000,
    parameter int unsigned CFG_DEPTH       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        irq_valid,
    input  logic [15:0] irq_qid,
    input  logic        cfg_change,
    output logic        notify_valid,
    output logic [15:0] notify_qid,
    output logic        msix_valid,
    output logic [15:0] msix_vector,
    input  logic [15:0] q_sel,
    output logic [31:0] q_pfn,
    output logic        drv_ok,
    output logic        dev_reset
);

    localparam int unsigned QW      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int unsigned AW      = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1;
    localparam logic [15:0] NQ      = 16'(NUM_QUEUES);
    localparam logic [15:0] QSIZE   = 16'(QUEUE_SIZE);
    localparam logic [31:0] CFG_END = OFF_CFG + 32'(4 * CFG_DEPTH);

    logic [31:0] guest_q, guest_d;
    logic [31:0] qaddr_q [NUM_QUEUES];
    logic [31:0] qaddr_d [NUM_QUEUES];
    logic [15:0] qvec_q  [NUM_QUEUES];
    logic [15:0] qvec_d  [NUM_QUEUES];
    logic [15:0] qsel_q, qsel_d;
    logic [7:0]  status_q, status_d;
    logic [1:0]  isr_q, isr_d;
    logic [15:0] cfg_vec_q, cfg_vec_d;
    logic [31:0] rdata_q, rdata_d, rd_mux;
    logic        ram_sel_q, ram_sel_d;
    logic        notify_valid_q, notify_valid_d;
    logic [15:0] notify_qid_q, notify_qid_d;
    logic        dev_reset_q, dev_reset_d;
    logic        msix_valid_q, msix_valid_d;
    logic [15:0] msix_vector_q, msix_vector_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] hold_vec_q, hold_vec_d;
    logic [31:0] q_pfn_q, q_pfn_d;

    logic [31:0]   waddr;
    logic [31:0]   ram_off;
    reg_e          rsel;
    logic          acc_wr, acc_rd, do_reset, q_in_rng, irq_ok, q_req, c_req;
    logic [QW-1:0] qidx;
    logic [15:0]   irq_vec;
    logic [31:0]   ram_rdata;
    logic          ram_en;
    logic [3:0]    unused_bits;

    assign waddr    = {addr[31:2], 2'b00};
    assign rsel     = decode_reg(waddr, CFG_END);
    assign acc_wr   = en && (we != 4'b0000);
    assign acc_rd   = en && (we == 4'b0000);
    assign q_in_rng = qsel_q < NQ;
    assign qidx     = qsel_q[QW-1:0];
    assign irq_ok   = irq_valid && (irq_qid < NQ);
    assign irq_vec  = qvec_q[irq_qid[QW-1:0]];
    assign q_req    = irq_ok && (irq_vec != NO_VECTOR);
    assign c_req    = cfg_change && (cfg_vec_q != NO_VECTOR);
    assign do_reset = acc_wr && (rsel == REG_NOTIFY_STATUS_ISR) && we[2] && (din[23:16] == 8'h00);
    assign ram_off  = waddr - OFF_CFG;
    assign ram_en   = en && (rsel == REG_CFG);
    assign unused_bits = {addr[1:0], ram_off[1:0]};

    virtio_cfg_ram #(
        .DEPTH (CFG_DEPTH),
        .AW    (AW)
    ) u_cfg_ram (
        .clk_i  (clk),
        .en_i   (ram_en),
        .we_i   (we),
        .addr_i (ram_off[AW+1:2]),
        .din_i  (din),
        .dout_o (ram_rdata)
    );

    always_comb begin
        rd_mux = '0;
        case (rsel)
            REG_DEV_FEAT:          rd_mux = DEVICE_FEATURES;
            REG_GUEST_FEAT:        rd_mux = guest_q;
            REG_QUEUE_ADDR:        rd_mux = q_in_rng ? qaddr_q[qidx] : '0;
            REG_QUEUE_SIZE_SEL:    rd_mux = {qsel_q, q_in_rng ? QSIZE : 16'h0000};
            REG_NOTIFY_STATUS_ISR: rd_mux = {6'b0, isr_q, status_q, 16'h0000};
            REG_MSIX:              rd_mux = {q_in_rng ? qvec_q[qidx] : NO_VECTOR, cfg_vec_q};
            default:               rd_mux = '0;
        endcase
    end

    always_comb begin
        guest_d        = guest_q;
        qaddr_d        = qaddr_q;
        qvec_d         = qvec_q;
        qsel_d         = qsel_q;
        status_d       = status_q;
        isr_d          = isr_q;
        cfg_vec_d      = cfg_vec_q;
        rdata_d        = rdata_q;
        ram_sel_d      = ram_sel_q;
        notify_valid_d = 1'b0;
        notify_qid_d   = notify_qid_q;
        dev_reset_d    = 1'b0;

        if (en) begin
            rdata_d   = rd_mux;
            ram_sel_d = (rsel == REG_CFG);
        end

        if (acc_wr) begin
            case (rsel)
                REG_GUEST_FEAT: begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (we[b]) guest_d[8*b +: 8] = din[8*b +: 8];
                    end
                end
                REG_QUEUE_ADDR: begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (we[b] && q_in_rng) qaddr_d[qidx][8*b +: 8] = din[8*b +: 8];
                    end
                end
                REG_QUEUE_SIZE_SEL: begin
                    if (we[2]) qsel_d[7:0]  = din[23:16];
                    if (we[3]) qsel_d[15:8] = din[31:24];
                end
                REG_NOTIFY_STATUS_ISR: begin
                    if (we[2]) status_d = din[23:16];
                    if (we[1:0] == 2'b11 && din[15:0] < NQ && !do_reset) begin
                        notify_valid_d = 1'b1;
                        notify_qid_d   = din[15:0];
                    end
                end
                REG_MSIX: begin
                    if (we[0]) cfg_vec_d[7:0]  = din[7:0];
                    if (we[1]) cfg_vec_d[15:8] = din[15:8];
                    if (we[2] && q_in_rng) qvec_d[qidx][7:0]  = din[23:16];
                    if (we[3] && q_in_rng) qvec_d[qidx][15:8] = din[31:24];
                end
                default: ;
            endcase
        end

        if (do_reset) begin
            guest_d     = '0;
            qsel_d      = '0;
            cfg_vec_d   = NO_VECTOR;
            dev_reset_d = 1'b1;
            for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
                qaddr_d[i] = '0;
                qvec_d[i]  = NO_VECTOR;
            end
        end

        // Clears are applied before sets so a same-cycle event survives the read.
        if ((acc_rd && rsel == REG_NOTIFY_STATUS_ISR) || do_reset) isr_d = '0;
        if (irq_ok)     isr_d[ISR_QUEUE]  = 1'b1;
        if (cfg_change) isr_d[ISR_CONFIG] = 1'b1;
    end

    // A held request goes out first; the first leftover takes the slot, others drop.
    always_comb begin
        msix_valid_d  = 1'b0;
        msix_vector_d = msix_vector_q;
        hold_valid_d  = 1'b0;
        hold_vec_d    = hold_vec_q;
        if (hold_valid_q) begin
            msix_valid_d  = 1'b1;
            msix_vector_d = hold_vec_q;
            if (q_req) begin
                hold_valid_d = 1'b1;
                hold_vec_d   = irq_vec;
            end else if (c_req) begin
                hold_valid_d = 1'b1;
                hold_vec_d   = cfg_vec_q;
            end
        end else if (q_req) begin
            msix_valid_d  = 1'b1;
            msix_vector_d = irq_vec;
            if (c_req) begin
                hold_valid_d = 1'b1;
                hold_vec_d   = cfg_vec_q;
            end
        end else if (c_req) begin
            msix_valid_d  = 1'b1;
            msix_vector_d = cfg_vec_q;
        end
    end

    assign q_pfn_d = (q_sel < NQ) ? qaddr_q[q_sel[QW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            guest_q        <= '0;
            qsel_q         <= '0;
            status_q       <= '0;
            isr_q          <= '0;
            cfg_vec_q      <= NO_VECTOR;
            for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
                qaddr_q[i] <= '0;
                qvec_q[i]  <= NO_VECTOR;
            end
            rdata_q        <= '0;
            ram_sel_q      <= 1'b0;
            notify_valid_q <= 1'b0;
            notify_qid_q   <= '0;
            dev_reset_q    <= 1'b0;
            msix_valid_q   <= 1'b0;
            msix_vector_q  <= '0;
            hold_valid_q   <= 1'b0;
            hold_vec_q     <= '0;
            q_pfn_q        <= '0;
        end else begin
            guest_q        <= guest_d;
            qsel_q         <= qsel_d;
            status_q       <= status_d;
            isr_q          <= isr_d;
            cfg_vec_q      <= cfg_vec_d;
            qaddr_q        <= qaddr_d;
            qvec_q         <= qvec_d;
            rdata_q        <= rdata_d;
            ram_sel_q      <= ram_sel_d;
            notify_valid_q <= notify_valid_d;
            notify_qid_q   <= notify_qid_d;
            dev_reset_q    <= dev_reset_d;
            msix_valid_q   <= msix_valid_d;
            msix_vector_q  <= msix_vector_d;
            hold_valid_q   <= hold_valid_d;
            hold_vec_q     <= hold_vec_d;
            q_pfn_q        <= q_pfn_d;
        end
    end

    assign dout         = ram_sel_q ? ram_rdata : rdata_q;
    assign notify_valid = notify_valid_q;
    assign notify_qid   = notify_qid_q;
    assign dev_reset    = dev_reset_q;
    assign msix_valid   = msix_valid_q;
    assign msix_vector  = msix_vector_q;
    assign q_pfn        = q_pfn_q;
    assign drv_ok       = status_q[STATUS_DRIVER_OK];

endmodule

// File: tb/tb_virtio_csr_mq.sv
// Scoreboard bench for virtio_csr_mq: expected read data and pulse values are
// queued as stimulus is driven and popped when the DUT responds.
module tb_virtio_csr_mq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        irq_valid = 1'b0;
    logic [15:0] irq_qid = '0;
    logic        cfg_change = 1'b0;
    logic        notify_valid;
    logic [15:0] notify_qid;
    logic        msix_valid;
    logic [15:0] msix_vector;
    logic [15:0] q_sel = '0;
    logic [31:0] q_pfn;
    logic        drv_ok;
    logic        dev_reset;

    int checks = 0;
    int passed = 0;

    logic [31:0] rd_exp[$];
    logic [15:0] notify_obs[$];
    logic [15:0] notify_exp[$];
    logic [15:0] msix_obs[$];
    logic [15:0] msix_exp[$];
    int          dev_reset_cnt = 0;

    virtio_csr_mq #(
        .NUM_QUEUES      (3),
        .QUEUE_SIZE      (256),
        .DEVICE_FEATURES (32'hA5A5_0001),
        .CFG_DEPTH       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .we           (we),
        .addr         (addr),
        .din          (din),
        .dout         (dout),
        .irq_valid    (irq_valid),
        .irq_qid      (irq_qid),
        .cfg_change   (cfg_change),
        .notify_valid (notify_valid),
        .notify_qid   (notify_qid),
        .msix_valid   (msix_valid),
        .msix_vector  (msix_vector),
        .q_sel        (q_sel),
        .q_pfn        (q_pfn),
        .drv_ok       (drv_ok),
        .dev_reset    (dev_reset)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (notify_valid) notify_obs.push_back(notify_qid);
        if (msix_valid)   msix_obs.push_back(msix_vector);
        if (dev_reset)    dev_reset_cnt++;
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                       output logic [31:0] rdata);
        en = 1'b1; we = w; addr = a; din = d;
        @(posedge clk); #1;
        en = 1'b0; we = '0;
        rdata = dout;
    endtask

    task automatic idle(input int n);
        en = 1'b0; we = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] r, e;
        logic [31:0] ra [3];
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dout, notify_valid, msix_valid, dev_reset, drv_ok, q_pfn} !== '0)
            $display("FAIL reset_outputs dout=%h nv=%b mv=%b dr=%b ok=%b pfn=%h required all zero",
                     dout, notify_valid, msix_valid, dev_reset, drv_ok, q_pfn);
        else passed++;
        rst = 1'b0;
        ra = '{32'h00, 32'h0C, 32'h14};
        rd_exp.push_back(32'hA5A5_0001);
        rd_exp.push_back(32'h0000_0100);
        rd_exp.push_back(32'hFFFF_FFFF);
        foreach (ra[i]) begin
            bus(ra[i], 4'b0000, '0, r);
            e = rd_exp.pop_front();
            checks++;
            if (r !== e) $display("FAIL reset_read[%0h] got %h required %h", ra[i], r, e);
            else passed++;
        end
    endtask

    task automatic test_queue_addr();
        logic [31:0] r, e;
        bus(32'h0C, 4'b1100, 32'h0001_0000, r);
        bus(32'h08, 4'b1111, 32'h0001_2345, r);
        rd_exp.push_back(32'h0001_2345);
        bus(32'h08, 4'b0000, '0, r);
        e = rd_exp.pop_front();
        checks++;
        if (r !== e) $display("FAIL qaddr_q1 got %h required %h", r, e); else passed++;
        q_sel = 16'd1;
        idle(1);
        checks++;
        if (q_pfn !== 32'h0001_2345) $display("FAIL q_pfn_q1 got %h required 00012345", q_pfn);
        else passed++;
        bus(32'h0C, 4'b1100, 32'h0000_0000, r);
        rd_exp.push_back(32'h0000_0000);
        bus(32'h08, 4'b0000, '0, r);
        e = rd_exp.pop_front();
        checks++;
        if (r !== e) $display("FAIL qaddr_q0 got %h required %h", r, e); else passed++;
        bus(32'h08, 4'b0010, 32'h5555_AB55, r);
        rd_exp.push_back(32'h0000_AB00);
        bus(32'h08, 4'b0000, '0, r);
        e = rd_exp.pop_front();
        checks++;
        if (r !== e) $display("FAIL qaddr_byte got %h required %h", r, e); else passed++;
    endtask

    task automatic test_oor_queue();
        logic [31:0] r, e;
        logic [31:0] ra [4];
        bus(32'h0C, 4'b1100, 32'h0005_0000, r);
        bus(32'h08, 4'b1111, 32'hDEAD_BEEF, r);
        bus(32'h14, 4'b1100, 32'h0009_0000, r);
        ra = '{32'h0C, 32'h08, 32'h14, 32'h0C};
        rd_exp.push_back(32'h0005_0000);
        rd_exp.push_back(32'h0000_0000);
        rd_exp.push_back(32'hFFFF_FFFF);
        rd_exp.push_back(32'h0005_0000);
        foreach (ra[i]) begin
            bus(ra[i], 4'b0000, '0, r);
            e = rd_exp.pop_front();
            checks++;
            if (r !== e) $display("FAIL oor_read[%0h] got %h required %h", ra[i], r, e);
            else passed++;
        end
        q_sel = 16'd5;
        idle(1);
        checks++;
        if (q_pfn !== 32'h0) $display("FAIL q_pfn_oor got %h required 0", q_pfn); else passed++;
        q_sel = 16'd1;
        idle(1);
        checks++;
        if (q_pfn !== 32'h0001_2345) $display("FAIL q_pfn_after_oor got %h required 00012345", q_pfn);
        else passed++;
    endtask

    task automatic test_notify();
        logic [31:0] r;
        logic [15:0] o, e;
        notify_obs.delete();
        notify_exp.push_back(16'd2);
        bus(32'h10, 4'b0011, 32'h0000_0002, r);
        checks++;
        if (notify_valid !== 1'b1 || notify_qid !== 16'd2)
            $display("FAIL notify_next_cycle valid=%b qid=%0d required 1/2", notify_valid, notify_qid);
        else passed++;
        bus(32'h10, 4'b0011, 32'h0000_0007, r);
        bus(32'h10, 4'b0001, 32'h0000_0001, r);
        idle(2);
        while (notify_exp.size() > 0 && notify_obs.size() > 0) begin
            e = notify_exp.pop_front();
            o = notify_obs.pop_front();
            checks++;
            if (o !== e) $display("FAIL notify_qid got %0d required %0d", o, e); else passed++;
        end
        checks++;
        if (notify_exp.size() != 0 || notify_obs.size() != 0)
            $display("FAIL notify_count leftover_obs=%0d leftover_exp=%0d required 0/0",
                     notify_obs.size(), notify_exp.size());
        else passed++;
    endtask

    task automatic test_msix_isr();
        logic [31:0] r, e;
        logic [15:0] o, ev;
        msix_obs.delete();
        bus(32'h0C, 4'b1100, 32'h0001_0000, r);
        bus(32'h14, 4'b1100, 32'h0003_0000, r);
        msix_exp.push_back(16'd3);
        irq_valid = 1'b1; irq_qid = 16'd1;
        idle(1);
        irq_valid = 1'b0;
        idle(2);
        rd_exp.push_back(32'h0100_0000);
        rd_exp.push_back(32'h0000_0000);
        repeat (2) begin
            bus(32'h10, 4'b0000, '0, r);
            e = rd_exp.pop_front();
            checks++;
            if (r !== e) $display("FAIL isr_read got %h required %h", r, e); else passed++;
        end
        bus(32'h14, 4'b0011, 32'h0000_0007, r);
        msix_exp.push_back(16'd3);
        msix_exp.push_back(16'd7);
        irq_valid = 1'b1; irq_qid = 16'd1; cfg_change = 1'b1;
        idle(1);
        irq_valid = 1'b0; cfg_change = 1'b0;
        idle(3);
        while (msix_exp.size() > 0 && msix_obs.size() > 0) begin
            ev = msix_exp.pop_front();
            o  = msix_obs.pop_front();
            checks++;
            if (o !== ev) $display("FAIL msix_vector got %0d required %0d", o, ev); else passed++;
        end
        checks++;
        if (msix_exp.size() != 0 || msix_obs.size() != 0)
            $display("FAIL msix_count leftover_obs=%0d leftover_exp=%0d required 0/0",
                     msix_obs.size(), msix_exp.size());
        else passed++;
        rd_exp.push_back(32'h0300_0000);
        bus(32'h10, 4'b0000, '0, r);
        e = rd_exp.pop_front();
        checks++;
        if (r !== e) $display("FAIL isr_both got %h required %h", r, e); else passed++;
    endtask

    task automatic test_dev_reset();
        logic [31:0] r, e;
        logic [31:0] ra [5];
        bus(32'h0C, 4'b1100, 32'h0001_0000, r);
        bus(32'h14, 4'b1111, 32'h0004_0005, r);
        bus(32'h08, 4'b1111, 32'h0000_ABCD, r);
        bus(32'h04, 4'b1111, 32'hFFFF_0000, r);
        bus(32'h10, 4'b0100, 32'h0007_0000, r);
        checks++;
        if (drv_ok !== 1'b1) $display("FAIL drv_ok_set got %b required 1", drv_ok); else passed++;
        notify_obs.delete();
        dev_reset_cnt = 0;
        bus(32'h10, 4'b0111, 32'h0000_0001, r);
        idle(2);
        checks++;
        if (dev_reset_cnt != 1 || notify_obs.size() != 0 || drv_ok !== 1'b0)
            $display("FAIL dev_reset_pulse pulses=%0d notifies=%0d drv_ok=%b required 1/0/0",
                     dev_reset_cnt, notify_obs.size(), drv_ok);
        else passed++;
        ra = '{32'h04, 32'h0C, 32'h08, 32'h14, 32'h10};
        rd_exp.push_back(32'h0000_0000);
        rd_exp.push_back(32'h0000_0100);
        rd_exp.push_back(32'h0000_0000);
        rd_exp.push_back(32'hFFFF_FFFF);
        rd_exp.push_back(32'h0000_0000);
        foreach (ra[i]) begin
            bus(ra[i], 4'b0000, '0, r);
            e = rd_exp.pop_front();
            checks++;
            if (r !== e) $display("FAIL dev_reset_read[%0h] got %h required %h", ra[i], r, e);
            else passed++;
        end
        q_sel = 16'd1;
        idle(1);
        checks++;
        if (q_pfn !== 32'h0) $display("FAIL q_pfn_after_reset got %h required 0", q_pfn); else passed++;
    endtask

    task automatic test_isr_race();
        logic [31:0] r, e;
        cfg_change = 1'b1;
        idle(1);
        cfg_change = 1'b0;
        rd_exp.push_back(32'h0200_0000);
        rd_exp.push_back(32'h0100_0000);
        rd_exp.push_back(32'h0000_0000);
        irq_valid = 1'b1; irq_qid = 16'd0;
        bus(32'h10, 4'b0000, '0, r);
        irq_valid = 1'b0;
        e = rd_exp.pop_front();
        checks++;
        if (r !== e) $display("FAIL isr_race_old got %h required %h", r, e); else passed++;
        repeat (2) begin
            bus(32'h10, 4'b0000, '0, r);
            e = rd_exp.pop_front();
            checks++;
            if (r !== e) $display("FAIL isr_race_after got %h required %h", r, e); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, e;
        bus(32'h18, 4'b1111, 32'h1122_3344, r);
        rd_exp.push_back(32'h1122_3344);
        bus(32'h18, 4'b0100, 32'h00AA_0000, r);
        e = rd_exp.pop_front();
        checks++;
        if (r !== e) $display("FAIL ram_read_first got %h required %h", r, e); else passed++;
        bus(32'h54, 4'b1111, 32'hCAFE_F00D, r);
        bus(32'h58, 4'b1111, 32'h1234_5678, r);
        rd_exp.push_back(32'h11AA_3344);
        rd_exp.push_back(32'hA5A5_0001);
        rd_exp.push_back(32'h0000_0000);
        rd_exp.push_back(32'hCAFE_F00D);
        bus(32'h18, 4'b0000, '0, r);
        e = rd_exp.pop_front(); checks++;
        if (r !== e) $display("FAIL b2b_ram0 got %h required %h", r, e); else passed++;
        bus(32'h00, 4'b0000, '0, r);
        e = rd_exp.pop_front(); checks++;
        if (r !== e) $display("FAIL b2b_devfeat got %h required %h", r, e); else passed++;
        bus(32'h58, 4'b0000, '0, r);
        e = rd_exp.pop_front(); checks++;
        if (r !== e) $display("FAIL b2b_beyond got %h required %h", r, e); else passed++;
        bus(32'h54, 4'b0000, '0, r);
        e = rd_exp.pop_front(); checks++;
        if (r !== e) $display("FAIL b2b_ram_last got %h required %h", r, e); else passed++;
        idle(3);
        checks++;
        if (dout !== 32'hCAFE_F00D) $display("FAIL dout_hold got %h required cafef00d", dout);
        else passed++;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rd_exp.push_back(32'h11AA_3344);
        bus(32'h18, 4'b0000, '0, r);
        e = rd_exp.pop_front(); checks++;
        if (r !== e) $display("FAIL ram_keep_on_reset got %h required %h", r, e); else passed++;
    endtask

    initial begin
        test_reset();
        test_queue_addr();
        test_oor_queue();
        test_notify();
        test_msix_isr();
        test_dev_reset();
        test_isr_race();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/virtio_csr_mq.md
# virtio_csr_mq

Legacy virtio-PCI common configuration register block, generalised to `NUM_QUEUES` virtqueues. It sits behind the AXI BRAM controller on BAR0, in place of the fixed 3-queue CSR. It adds proper per-byte writes, device reset via status write, a read-to-clear ISR, and queue-notify and MSI-X request outputs toward the queue engine. Device-specific config space (offset 0x18 and up) is backed by a byte-write RAM.

## Interface
- `NUM_QUEUES`, 3: number of virtqueues, 1..64
- `QUEUE_SIZE`, 256: value reported in Queue Size for every implemented queue
- `DEVICE_FEATURES`, 32'h0000_0000: read-only Device Features word
- `CFG_DEPTH`, 16: 32-bit words of device-specific config starting at 0x18
- `clk` in 1: single clock for all logic
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: BRAM-port access enable
- `we` in 4: byte write enables; all zero means read
- `addr` in 32: byte address; word index is `addr[31:2]`
- `din` in 32: write data
- `dout` out 32: read data, 1-cycle latency
- `irq_valid` in 1: queue-interrupt request from the queue engine
- `irq_qid` in 16: queue of the `irq_valid` request
- `cfg_change` in 1: device-config-change event
- `notify_valid` out 1: one-cycle pulse on a Queue Notify write
- `notify_qid` out 16: queue index written to Queue Notify
- `msix_valid` out 1: one-cycle MSI-X request pulse
- `msix_vector` out 16: vector for `msix_valid`
- `q_sel` in 16: queue-engine lookup index
- `q_pfn` out 32: Queue Address of `q_sel`, registered
- `drv_ok` out 1: Device Status DRIVER_OK bit
- `dev_reset` out 1: one-cycle pulse when the driver writes status 0

## Operation
- Register map. Fields are little-endian within each word and addressed by byte lane.
  - 0x00 Device Features: read-only.
  - 0x04 Guest Features: read/write.
  - 0x08 Queue Address: 32-bit, per selected queue.
  - 0x0C[15:0] Queue Size: read-only, per selected queue.
  - 0x0C[31:16] Queue Select.
  - 0x10[15:0] Queue Notify: write-only, reads 0.
  - 0x10[23:16] Device Status.
  - 0x10[31:24] ISR.
  - 0x14[15:0] Config MSI-X Vector.
  - 0x14[31:16] Queue MSI-X Vector: per selected queue.
  - 0x18 onward: config RAM.
  - Beyond 0x18+4*CFG_DEPTH: reads 0, writes ignored.
- Writes honour each `we` bit independently. A partial 16/32-bit field write updates only the enabled bytes.
- Selected queue is out of range (`Queue Select >= NUM_QUEUES`):
  - per-queue writes are ignored;
  - Queue Address and Queue Size read 0, signalling an absent queue;
  - Queue MSI-X Vector reads 16'hFFFF.
- Queue Notify write (`we[1:0]==2'b11`): `notify_valid`=1 and `notify_qid`=`din[15:0]` on the next cycle.
  - Out-of-range qid: the notify is dropped.
  - Single-byte writes to the notify field are ignored.
- Device Status write of 8'h00 (byte lane 2 enabled) performs a device reset:
  - clears Guest Features, every Queue Address, Queue Select, ISR;
  - sets every MSI-X vector to 16'hFFFF (NO_VECTOR);
  - pulses `dev_reset`;
  - a Notify in the same write is dropped.
- ISR bit0 is set by an in-range `irq_valid`. Bit1 is set by `cfg_change`.
- Any read of word 0x10 returns ISR, then clears it.
  - If a set and a clear occur in the same cycle, the set wins: the returned value is the old value, and the new bit stays set afterwards.
- On an in-range `irq_valid`:
  - if the queue's vector is not FFFF, `msix_valid` pulses next cycle with that vector;
  - `cfg_change` likewise uses the Config MSI-X Vector.
  - If both fire in the same cycle, the queue request goes first and the config request is held one cycle. There is one holding slot; further overlap is dropped and ISR still records it.
- `drv_ok` = Device Status bit 2.

## Timing
- `dout` is registered: the access in cycle N returns data in cycle N+1.
  - A read returns the pre-write value when a read and a write hit the same address (read-first).
  - `dout` holds its value when `en`=0.
- Writes take effect at the end of the access cycle. Queue Select written in cycle N steers per-queue accesses from cycle N+1.
- `q_pfn` is valid one cycle after `q_sel`.
- Reset (`rst`=1 at a clock edge): all of the following take their reset values at that edge:
  - registers clear to 0;
  - MSI-X vectors set to FFFF;
  - `dout`, `notify_valid`, `msix_valid`, `dev_reset`, `drv_ok` and `q_pfn` = 0;
  - a pending held MSI-X request is discarded;
  - config RAM contents are preserved.

## Structure
- Package `virtio_csr_pkg`:
  - register byte offsets;
  - `NO_VECTOR` = 16'hFFFF;
  - status bit indices (ACK, DRIVER, DRIVER_OK, FAILED);
  - ISR bit indices.
- Sub-module `virtio_cfg_ram`: single-port, byte-write, read-first RAM with 1-cycle latency, `CFG_DEPTH`×32.
- Per-queue state (Queue Address, Queue MSI-X Vector) is held in `NUM_QUEUES`-entry register arrays.

## Test plan
- Write 0x0C with `we`=1100, `din`=0x0001_0000, then write 0x08 with `din`=0x0001_2345 -> reading 0x08 returns 0x0001_2345, `q_sel`=1 gives `q_pfn`=0x0001_2345, and queue 0 still reads 0.
- Select queue 5 with `NUM_QUEUES`=3 -> 0x0C reads 0x0005_0000, 0x08 reads 0, and a write to 0x08 changes nothing.
- Write 0x10 with `we`=0011, `din`=0x0002 -> `notify_valid` pulses one cycle with `notify_qid`=2; `din`=0x0007 produces no pulse.
- Set the queue-1 vector to 3, then pulse `irq_valid` with qid 1 -> `msix_valid` with vector 3; read 0x10 returns ISR=0x01, and the next read returns 0x00.
- Program status 0x07 and all vectors, then write status 0x00 -> `dev_reset` pulses, Queue Address and features read 0, and vectors read 0xFFFF.
- `irq_valid` in the same cycle as an ISR read -> the read returns the old ISR, and bit0 remains set.
